psum_acc_seq: RTL and testbench

Hardware accumulation sequencer that sits downstream of the core's partial-sum SRAM (pmem). It replaces the bench-driven address list used during accumulation. For each output pixel it generates the pmem read addresses for all kernel positions and accumulates the returned per-column psums. It applies optional ReLU and presents one 8-column output word per pixel under a valid/ready handshake.

---
 rtl/psum_acc_seq_if.sv | 25 ++
 rtl/psum_acc_seq.sv | 137 +++++++++++++
 tb/tb_psum_acc_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_seq_if.sv
// Bundles the pmem read port and the output word stream of the psum
// accumulation sequencer; master is the sequencer, slave is memory plus consumer.
interface psum_acc_seq_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
);
    logic                     CEN_pmem;
    logic                     WEN_pmem;
    logic [addr_w-1:0]        A_pmem;
    logic [psum_bw*col-1:0]   Q_pmem;
    logic [psum_bw*col-1:0]   out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output CEN_pmem, WEN_pmem, A_pmem, out_data, out_valid,
        input  Q_pmem, out_ready
    );

    modport slave (
        input  CEN_pmem, WEN_pmem, A_pmem, out_data, out_valid,
        output Q_pmem, out_ready
    );
endinterface

// File: rtl/psum_acc_seq.sv
// Accumulation sequencer: walks every output pixel, reads the psum of each
// kernel position from pmem, sums per column and emits one (ReLU'd) word per pixel.
module psum_acc_seq #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int in_w    = 8,
    parameter int ksz     = 3,
    parameter int addr_w  = 11,
    parameter int base    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                relu_en,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg,
    psum_acc_seq_if.master      bus
);
    localparam int O_W = in_w - ksz + 1;
    localparam int NIJ = in_w * in_w;
    localparam int CW  = $clog2(in_w);
    localparam int KW  = $clog2(ksz * ksz);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                    state;
    logic [CW-1:0]                 ox, oy, kx, ky;
    logic [KW-1:0]                 kij;
    logic                          relu_q;
    logic                          rd_vld, rd_first;
    logic [col-1:0][psum_bw-1:0]   acc;
    logic                          last_k, last_pix;
    logic [addr_w-1:0]             addr;

    assign last_k   = (kx == CW'(ksz - 1)) && (ky == CW'(ksz - 1));
    assign last_pix = (ox == CW'(O_W - 1)) && (oy == CW'(O_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            ox     <= '0;
            oy     <= '0;
            kx     <= '0;
            ky     <= '0;
            kij    <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_ISSUE;
                    relu_q <= relu_en;
                    ox     <= '0;
                    oy     <= '0;
                    kx     <= '0;
                    ky     <= '0;
                    kij    <= '0;
                end
                S_ISSUE: begin
                    if (last_k) begin
                        kx    <= '0;
                        ky    <= '0;
                        kij   <= '0;
                        state <= S_DRAIN;
                    end else if (kx == CW'(ksz - 1)) begin
                        kx  <= '0;
                        ky  <= ky + 1'b1;
                        kij <= kij + 1'b1;
                    end else begin
                        kx  <= kx + 1'b1;
                        kij <= kij + 1'b1;
                    end
                end
                S_DRAIN: state <= S_OUT;
                // out_data is held until the consumer takes it; only then move on
                S_OUT: if (bus.out_ready) begin
                    if (last_pix) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                        if (ox == CW'(O_W - 1)) begin
                            ox <= '0;
                            oy <= oy + 1'b1;
                        end else begin
                            ox <= ox + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data lands one cycle after its issue; kij=0 data reloads the sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld   <= 1'b0;
            rd_first <= 1'b0;
            acc      <= '0;
        end else begin
            rd_vld   <= (state == S_ISSUE);
            rd_first <= (state == S_ISSUE) && (kij == '0);
            if (rd_vld) begin
                for (int c = 0; c < col; c++) begin
                    acc[c] <= rd_first ? bus.Q_pmem[c*psum_bw +: psum_bw]
                                       : acc[c] + bus.Q_pmem[c*psum_bw +: psum_bw];
                end
            end
        end
    end

    always_comb begin
        addr = addr_w'(base) + addr_w'(kij) * addr_w'(NIJ)
             + addr_w'(oy + ky) * addr_w'(in_w) + addr_w'(ox + kx);
    end

    // Handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never drops before that transfer.
    always_comb begin
        bus.CEN_pmem  = (state != S_ISSUE);
        bus.WEN_pmem  = 1'b1;
        bus.A_pmem    = (state == S_ISSUE) ? addr : '0;
        bus.out_valid = (state == S_OUT);
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        state_dbg     = state;
        bus.out_data  = '0;
        for (int c = 0; c < col; c++) begin
            bus.out_data[c*psum_bw +: psum_bw] = (relu_q && acc[c][psum_bw-1]) ? '0 : acc[c];
        end
    end
endmodule

// File: tb/tb_psum_acc_seq.sv
// Bench for psum_acc_seq: pmem model, directed vector table, backpressure,
// reset abort and randomized passes against a pixel-sum reference model.
module tb_psum_acc_seq;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int AW  = 11;
  localparam int W   = COL * PBW;
  localparam int BASE = 0;

  logic clk = 1'b0;
  logic reset, start, relu_en;
  logic busy, done;
  logic [2:0] state_dbg;

  psum_acc_seq_if #(.col(COL), .psum_bw(PBW), .addr_w(AW)) bus ();

  psum_acc_seq #(.col(COL), .psum_bw(PBW), .in_w(8), .ksz(3), .addr_w(AW), .base(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .state_dbg(state_dbg), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pmem model: one-cycle read latency, garbage when not reading
  logic [W-1:0]  mem [0:2047];
  logic [W-1:0]  q_reg;
  logic [AW-1:0] rd_q[$];
  assign bus.Q_pmem = q_reg;
  always @(posedge clk) begin
    if (!bus.CEN_pmem) begin
      q_reg <= mem[bus.A_pmem];
      rd_q.push_back(bus.A_pmem);
    end else begin
      q_reg <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int bp_hold;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: sum over the 3x3 window of the pmem psums, wrap, ReLU
  function automatic logic [W-1:0] model_pixel(input int p, input bit relu);
    int oy = p / 6;
    int ox = p % 6;
    logic [PBW-1:0] s [COL];
    logic [W-1:0] w, r;
    for (int c = 0; c < COL; c++) s[c] = '0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        w = mem[BASE + (ky*3 + kx)*64 + (oy + ky)*8 + ox + kx];
        for (int c = 0; c < COL; c++) s[c] = s[c] + w[c*PBW +: PBW];
      end
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = (relu && s[c][PBW-1]) ? '0 : s[c];
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic fill_const(input logic [W-1:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  // driver: one full pass; ready_mode 0=always, 1=random, 2=stall pixel 3 for 20 cycles
  task automatic run_pass(input bit relu, input int ready_mode, input bit inject, output int done_at);
    int n;
    bit seen_done, r;
    logic [W-1:0] held;
    got_q.delete();
    rd_q.delete();
    done_at = -1;
    seen_done = 0;
    bp_hold = 0;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    relu_en = relu;
    bus.out_ready = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (inject && n == 50) begin
        start = 1'b1;
        relu_en = ~relu;
      end
      if (n == 1) begin
        check("busy_after_start", busy, 1);
        check("first_read_cen", bus.CEN_pmem, 0);
      end
      if (seen_done) begin
        check("busy_falls_after_done", busy, 0);
        check("done_single_pulse", done, 0);
        break;
      end
      if (done) begin
        done_at = n;
        seen_done = 1;
      end
      r = 1'b1;
      if (ready_mode == 1) r = 1'($urandom_range(0, 1));
      if (ready_mode == 2 && ((bp_hold > 0 && bp_hold < 20) ||
                              (bp_hold == 0 && bus.out_valid && got_q.size() == 3))) begin
        if (bp_hold == 0) held = bus.out_data;
        else begin
          check("bp_valid_held", bus.out_valid, 1);
          check("bp_data_stable", bus.out_data, held);
        end
        check("bp_cen_idle", bus.CEN_pmem, 1);
        bp_hold++;
        r = 1'b0;
      end
      bus.out_ready = r;
      if (bus.out_valid && r) got_q.push_back(bus.out_data);
    end
    check("pass_done_seen", seen_done, 1);
  endtask

  task automatic compare_pass(input bit relu);
    logic [W-1:0] e, a;
    for (int p = 0; p < 36; p++) exp_q.push_back(model_pixel(p, relu));
    check("word_count", got_q.size(), 36);
    for (int i = 0; i < 36; i++) begin
      e = exp_q.pop_front();
      a = (i < got_q.size()) ? got_q[i] : 'x;
      check($sformatf("pixel%0d", i), a, e);
    end
  endtask

  task automatic check_addrs();
    logic [AW-1:0] first9 [9] = '{11'd0, 11'd65, 11'd130, 11'd200, 11'd265,
                                  11'd330, 11'd400, 11'd465, 11'd530};
    int i;
    check("read_count", rd_q.size(), 324);
    for (int k = 0; k < 9; k++) check($sformatf("onij0_read%0d", k), rd_q[k], first9[k]);
    check("last_read", rd_q[323], 575);
    i = 0;
    for (int p = 0; p < 36; p++)
      for (int k = 0; k < 9; k++) begin
        if (rd_q[i] !== AW'(BASE + k*64 + (p/6 + k/3)*8 + p%6 + k%3)) begin
          check($sformatf("addr_p%0d_k%0d", p, k), rd_q[i], AW'(BASE + k*64 + (p/6 + k/3)*8 + p%6 + k%3));
        end
        i++;
      end
    check("addr_walk_len", i, rd_q.size());
  endtask

  typedef struct {
    string       name;
    logic [15:0] c0, c1, rest;
    bit          relu;
    logic [15:0] e0, e1, erest;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [W-1:0] w, e;
    int done_at;
    bit saw_done;

    vecs[0] = '{"wrap_7fff",     16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FF7, 16'h7FF7, 16'h7FF7};
    vecs[1] = '{"relu_on",       16'hFFFB, 16'h0003, 16'h0000, 1'b1, 16'h0000, 16'h001B, 16'h0000};
    vecs[2] = '{"relu_off",      16'hFFFB, 16'h0003, 16'h0000, 1'b0, 16'hFFD3, 16'h001B, 16'h0000};
    vecs[3] = '{"relu_msb_8000", 16'h8000, 16'h8000, 16'h0001, 1'b1, 16'h0000, 16'h0000, 16'h0009};
    vecs[4] = '{"mixed_wrap",    16'h8000, 16'hFFFF, 16'h1234, 1'b0, 16'h8000, 16'hFFF7, 16'hA3D4};

    reset = 1'b1;
    start = 1'b0;
    relu_en = 1'b0;
    bus.out_ready = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cen", bus.CEN_pmem, 1);
    check("rst_wen", bus.WEN_pmem, 1);
    check("rst_addr", bus.A_pmem, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // golden pass with an ignored start (and relu flip) mid-pass
    run_pass(1'b0, 0, 1'b1, done_at);
    check("done_at_397", done_at, 397);
    compare_pass(1'b0);
    check_addrs();

    // directed vector table
    for (int v = 0; v < 5; v++) begin
      w = {vecs[v].rest, vecs[v].rest, vecs[v].rest, vecs[v].rest,
           vecs[v].rest, vecs[v].rest, vecs[v].c1, vecs[v].c0};
      e = {vecs[v].erest, vecs[v].erest, vecs[v].erest, vecs[v].erest,
           vecs[v].erest, vecs[v].erest, vecs[v].e1, vecs[v].e0};
      fill_const(w);
      run_pass(vecs[v].relu, 0, 1'b0, done_at);
      check({vecs[v].name, "_done_at"}, done_at, 397);
      check({vecs[v].name, "_count"}, got_q.size(), 36);
      for (int i = 0; i < 36; i++)
        check($sformatf("%s_px%0d", vecs[v].name, i), (i < got_q.size()) ? got_q[i] : 'x, e);
    end

    // backpressure on pixel 3
    fill_random();
    run_pass(1'b1, 2, 1'b0, done_at);
    check("bp_hold_cycles", bp_hold, 20);
    compare_pass(1'b1);

    // reset during pixel 10 ISSUE
    fill_random();
    @(negedge clk);
    start = 1'b1;
    relu_en = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10*11 + 3) @(negedge clk);
    check("pix10_issuing", bus.CEN_pmem, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_cen", bus.CEN_pmem, 1);
    check("abort_valid", bus.out_valid, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("abort_stays_idle", saw_done, 0);
    run_pass(1'b0, 0, 1'b0, done_at);
    check("after_abort_pix0", (got_q.size() > 0) ? got_q[0] : 'x, model_pixel(0, 1'b0));
    compare_pass(1'b0);

    // randomized passes with random ready
    for (int t = 0; t < 3; t++) begin
      bit rl;
      fill_random();
      rl = 1'($urandom_range(0, 1));
      run_pass(rl, 1, 1'b0, done_at);
      compare_pass(rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
